// File: rtl/zmod_capture_pkg.sv
// rtl/zmod_capture_pkg.sv - shared state encoding and widths for the ZMOD capture buffer
package zmod_capture_pkg;
    localparam int SAMPLE_W = 14;
    localparam int WORD_W   = 2 * SAMPLE_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_WAIT_TRIG,
        S_POST,
        S_DONE
    } cap_state_e;
endpackage

// File: rtl/zmod_capture_ram.sv
// rtl/zmod_capture_ram.sv - simple dual-port capture RAM with registered read port
module zmod_capture_ram
    import zmod_capture_pkg::*;
#(
    parameter int P_AW = 10,
    parameter int P_DW = WORD_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we_i,
    input  logic [P_AW-1:0] waddr_i,
    input  logic [P_DW-1:0] wdata_i,
    input  logic [P_AW-1:0] raddr_i,
    output logic [P_DW-1:0] rdata_o
);
    logic [P_DW-1:0] mem_q [1<<P_AW];

    // Array kept free of reset so it maps onto block RAM; only the output register clears.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst) rdata_o <= '0;
        else     rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/zmod_adc_capture.sv
// rtl/zmod_adc_capture.sv - triggered A/B sample capture window; ZMOD_CAPTURE_DECIM_EN adds decimation
module zmod_adc_capture
    import zmod_capture_pkg::*;
#(
    parameter int P_DEPTH_LOG2 = 10,
    parameter int P_PRETRIG    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_W-1:0]     i14_data_a,
    input  logic [SAMPLE_W-1:0]     i14_data_b,
    input  logic                    i_data_valid,
    input  logic                    i_adc_configured,
    input  logic                    i_arm,
    input  logic                    i_force_trig,
    input  logic [SAMPLE_W-1:0]     i14_trig_level,
    input  logic                    i_trig_edge,
`ifdef ZMOD_CAPTURE_DECIM_EN
    input  logic [7:0]              i8_decim,
`endif
    output logic                    or_busy,
    output logic                    or_triggered,
    output logic                    or_done,
    input  logic [P_DEPTH_LOG2-1:0] i_rd_addr,
    output logic [WORD_W-1:0]       o28_rd_data
);
    localparam int AW      = P_DEPTH_LOG2;
    localparam int P_DEPTH = 1 << AW;
    localparam int POST_N  = P_DEPTH - P_PRETRIG - 1;
    localparam logic [AW-1:0] PRE_LAST  = AW'((P_PRETRIG > 0) ? P_PRETRIG - 1 : 0);
    localparam logic [AW-1:0] POST_LAST = AW'((POST_N > 0) ? POST_N - 1 : 0);

    cap_state_e state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, start_q, start_d, cnt_q, cnt_d;
    logic signed [SAMPLE_W-1:0] prev_a_q, prev_a_d;
    logic prev_vld_q, prev_vld_d, force_q, force_d, trig_q, trig_d;
    logic signed [SAMPLE_W-1:0] cur_a, lvl;
    logic arm_ok, acc, hit, we;

    assign cur_a   = i14_data_a;
    assign lvl     = i14_trig_level;
    assign or_busy = (state_q == S_PREFILL) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
    assign arm_ok  = i_arm && i_adc_configured && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign hit     = prev_vld_q && (i_trig_edge ? ((prev_a_q > lvl) && (cur_a <= lvl))
                                                : ((prev_a_q < lvl) && (cur_a >= lvl)));

`ifdef ZMOD_CAPTURE_DECIM_EN
    logic [7:0] dec_q, dec_d;

    // The first valid after arm is always taken, then every (i8_decim+1)-th one.
    assign acc = i_data_valid && (dec_q == 8'd0);

    always_comb begin
        dec_d = dec_q;
        if (arm_ok)                      dec_d = 8'd0;
        else if (i_data_valid && or_busy) dec_d = (dec_q >= i8_decim) ? 8'd0 : dec_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) dec_q <= 8'd0;
        else     dec_q <= dec_d;
    end
`else
    assign acc = i_data_valid;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            start_q    <= '0;
            cnt_q      <= '0;
            prev_a_q   <= '0;
            prev_vld_q <= 1'b0;
            force_q    <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            start_q    <= start_d;
            cnt_q      <= cnt_d;
            prev_a_q   <= prev_a_d;
            prev_vld_q <= prev_vld_d;
            force_q    <= force_d;
            trig_q     <= trig_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        start_d    = start_q;
        cnt_d      = cnt_q;
        prev_a_d   = prev_a_q;
        prev_vld_d = prev_vld_q;
        force_d    = force_q;
        trig_d     = trig_q;
        we         = 1'b0;

        if (or_busy && acc) begin
            we         = 1'b1;
            wr_ptr_d   = wr_ptr_q + AW'(1);
            prev_a_d   = cur_a;
            prev_vld_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm_ok) begin
                    trig_d     = 1'b0;
                    cnt_d      = '0;
                    prev_vld_d = 1'b0;
                    force_d    = 1'b0;
                    state_d    = (P_PRETRIG == 0) ? S_WAIT_TRIG : S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (acc) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == PRE_LAST) state_d = S_WAIT_TRIG;
                end
            end
            S_WAIT_TRIG: begin
                if (i_force_trig) force_d = 1'b1;
                // Level hit and pending force on the same sample collapse into one trigger.
                if (acc && (hit || force_q)) begin
                    start_d = wr_ptr_q - AW'(P_PRETRIG);
                    trig_d  = 1'b1;
                    force_d = 1'b0;
                    cnt_d   = '0;
                    state_d = (POST_N == 0) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (acc) begin
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == POST_LAST) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign or_triggered = trig_q;
    assign or_done      = (state_q == S_DONE);

    zmod_capture_ram #(
        .P_AW (AW),
        .P_DW (WORD_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i ({i14_data_a, i14_data_b}),
        .raddr_i (start_q + i_rd_addr),
        .rdata_o (o28_rd_data)
    );
endmodule

// File: doc/zmod_adc_capture.md
# zmod_adc_capture

Triggered sample-capture buffer downstream of the ZMOD ADC driver. It takes the de-interleaved 14-bit channel A/B samples and stores a window of P_DEPTH sample pairs around a level or forced trigger, with P_PRETRIG samples of pre-trigger history. After capture, the processor side reads the window in trigger-aligned order.

## Interface
Parameters:
- P_DEPTH_LOG2, 10: log2 of the buffer depth (P_DEPTH = 1024 sample pairs).
- P_PRETRIG, 64: samples kept before the trigger sample. Legal range 0..P_DEPTH-1.

Ports:
- clk  in  1  system clock. One clock; all logic is in this domain.
- rst  in  1  reset, synchronous, active-high.
- i14_data_a  in  14  channel A sample, signed two's complement.
- i14_data_b  in  14  channel B sample, signed two's complement.
- i_data_valid  in  1  sample strobe, one cycle per sample pair.
- i_adc_configured  in  1  ADC driver configuration-complete flag.
- i_arm  in  1  one-cycle pulse that starts a capture.
- i_force_trig  in  1  one-cycle pulse that triggers immediately, subject to the pre-trigger rule.
- i14_trig_level  in  14  signed trigger threshold, compared against channel A.
- i_trig_edge  in  1  trigger slope: 0 = rising, 1 = falling.
- or_busy  out  1  capture in progress.
- or_triggered  out  1  trigger seen in the current capture.
- or_done  out  1  window complete and readable.
- i_rd_addr  in  P_DEPTH_LOG2  logical read index; 0 = oldest pre-trigger sample.
- o28_rd_data  out  28  {A[13:0], B[13:0]} at i_rd_addr.

## Operation
- The state machine has five states: IDLE, PREFILL, WAIT_TRIG, POST, DONE.
- IDLE:
  - i_arm is accepted only when i_adc_configured = 1; it moves the FSM to PREFILL.
  - Accepting i_arm clears or_triggered and or_done and zeroes the pre-fill count.
- PREFILL:
  - Every accepted sample is written at the write pointer, which then increments. The pointer wraps mod P_DEPTH.
  - After P_PRETRIG samples the FSM moves to WAIT_TRIG. With P_PRETRIG = 0 it goes straight to WAIT_TRIG.
- WAIT_TRIG:
  - Samples keep writing circularly.
  - Rising trigger: prev_a < level AND cur_a >= level (signed compare).
  - Falling trigger: prev_a > level AND cur_a <= level.
  - prev_a is the last accepted channel A sample. It is invalidated on arm, so the first sample after arm cannot trigger.
  - i_force_trig acts as a trigger on the next accepted sample.
  - On trigger, the trigger sample is written, start_addr is latched as (trigger address − P_PRETRIG) mod P_DEPTH, and the FSM moves to POST.
- POST:
  - The FSM writes P_DEPTH − P_PRETRIG − 1 further samples, then moves to DONE.
  - The trigger sample sits at logical index P_PRETRIG.
- DONE:
  - No writes occur.
  - i_arm re-enters PREFILL if i_adc_configured = 1.
- i_arm while busy is ignored. i_force_trig outside WAIT_TRIG is ignored.
- A level trigger and a force on the same sample count as a single trigger.
- Dropping i_adc_configured after arm has no effect on an ongoing capture.
- Read path: physical address = (start_addr + i_rd_addr) mod P_DEPTH. Reads are valid in any state; contents are only meaningful once or_done = 1.
- rst mid-capture returns the FSM to IDLE. Buffer contents are not cleared.

## Timing
- Reset values: or_busy = 0, or_triggered = 0, or_done = 0, o28_rd_data = 0, FSM = IDLE, write pointer = 0, start_addr = 0.
- Status flags:
  - or_busy = 1 the cycle after i_arm is accepted, and stays high through PREFILL, WAIT_TRIG and POST.
  - or_triggered rises the cycle after the trigger sample's valid cycle.
  - or_done rises, and or_busy falls, the cycle after the last POST sample's valid cycle.
- RAM write occurs in the same cycle as i_data_valid.
- Read latency: o28_rd_data is registered, 1 cycle after i_rd_addr.
- Samples are accepted at up to one per cycle; i_data_valid may be held high continuously.

## Configuration
- ZMOD_CAPTURE_DECIM_EN defined:
  - Adds port i8_decim (in, 8).
  - Only every (i8_decim+1)-th valid sample is accepted. Trigger detection, pre-fill counting and writes all operate on the accepted stream.
  - The decimation counter resets on arm.
  - i8_decim = 0 behaves identically to the undefined case.
- Undefined: every i_data_valid sample is accepted; port i8_decim is absent.

## Structure
- Package zmod_capture_pkg holds:
  - the FSM state encoding;
  - the sample width (14) and the packed word width (28).
- Sub-module zmod_capture_ram: simple dual-port RAM, P_DEPTH × 28, one write port and one registered read port, inferable as block RAM.

## Test plan
- P_PRETRIG = 64, rising edge, level 0, ramp on A from −512 step +1 per valid → trigger on the sample A = 0; after done, read index 64 → A = 0, index 0 → A = −64, index 1023 → A = 959.
- Falling edge, level 100, A steps 200, 200, 50 after prefill → trigger on A = 50; A steady at 200 produces no trigger.
- i_arm with i_adc_configured = 0 → or_busy stays 0; i_arm while busy → no restart, write count unchanged.
- i_force_trig pulsed during PREFILL is ignored; pulsed in WAIT_TRIG → trigger on the next valid sample, which sits at index 64.
- rst asserted in POST → all outputs 0 the next cycle; re-arm → a full new capture completes.
- With ZMOD_CAPTURE_DECIM_EN, i8_decim = 3 and a continuous valid ramp 0, 1, 2, … → stored A values step by 4.
